mc_controller: RTL and testbench

Multicycle MIPS control unit: a Moore state machine sequencing fetch, decode, execute, memory and write-back over several cycles, sharing one ALU and one memory port. It sits beside the multicycle datapath and drives its enables and muxes from the opcode and funct fields latched in the instruction register. Compared with the single-cycle controller, it adds:

- a memory ready/request handshake with wait states;
- parametrised immediate-logic and bne support;
- an illegal-opcode flag.

---
 rtl/mc_controller.sv | 206 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control unit (Moore FSM) with a memory
// ready/request handshake, optional bne and andi/ori decode, and an
// illegal-instruction pulse.
//
// Ports:
//   clk, reset (async, active low)
//   op, funct     - IR opcode / function fields
//   zero          - ALU zero flag (only affects pcen in BRANCH)
//   memready      - memory finishes the current access this cycle
//   memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//   alusrca, alusrcb, pcsrc, pcen, sig, alucontrol - datapath controls
//   illegal       - one-cycle pulse on an undecodable op or funct
module mc_controller #(
  parameter int unsigned ALUCTRL_W     = 3,
  parameter bit          HAS_BNE       = 1'b1,
  parameter bit          HAS_LOGIC_IMM = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 memready,
  output logic                 memreq,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic                 sig,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] EXECUTE = 4'd6;
  localparam logic [3:0] ALUWB   = 4'd7;
  localparam logic [3:0] BRANCH  = 4'd8;
  localparam logic [3:0] IMMEX   = 4'd9;
  localparam logic [3:0] IMMWB   = 4'd10;
  localparam logic [3:0] JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state_q, state_d;
  logic [2:0] alu3;
  logic       pcwrite, branch;
  logic       is_bne, is_logic_imm;

  assign is_bne       = HAS_BNE && (op == OP_BNE);
  assign is_logic_imm = HAS_LOGIC_IMM && ((op == OP_ANDI) || (op == OP_ORI));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    memreq   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    sig      = 1'b1;
    alu3     = ALU_AND;
    illegal  = 1'b0;
    case (state_q)
      FETCH: begin
        memreq  = 1'b1;
        alusrcb = 2'b01;
        alu3    = ALU_ADD;
        // Gated by reset so nothing commits while reset is held.
        irwrite = memready & reset;
        pcwrite = memready & reset;
        if (memready) state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        alu3    = ALU_ADD;
        if ((op == OP_LW) || (op == OP_SW))            state_d = MEMADR;
        else if (op == OP_RTYPE)                        state_d = EXECUTE;
        else if ((op == OP_BEQ) || is_bne)              state_d = BRANCH;
        else if ((op == OP_ADDI) || (op == OP_SLTI) || is_logic_imm) state_d = IMMEX;
        else if (op == OP_J)                            state_d = JUMP;
        else begin
          state_d = FETCH;
          illegal = 1'b1;
        end
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alu3    = ALU_ADD;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
        if (memready) state_d = MEMWB;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        memreq   = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (memready) state_d = FETCH;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        state_d = ALUWB;
        case (funct)
          6'b100000: alu3 = ALU_ADD;
          6'b100010: alu3 = ALU_SUB;
          6'b100100: alu3 = ALU_AND;
          6'b100101: alu3 = ALU_OR;
          6'b101010: alu3 = ALU_SLT;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        alusrca = 1'b1;
        alu3    = ALU_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = FETCH;
      end
      IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = IMMWB;
        case (op)
          OP_SLTI: alu3 = ALU_SLT;
          OP_ANDI: begin
            alu3 = ALU_AND;
            sig  = 1'b0;
          end
          OP_ORI: begin
            alu3 = ALU_OR;
            sig  = 1'b0;
          end
          default: alu3 = ALU_ADD;
        endcase
      end
      IMMWB: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // bne inverts the zero test; branch is only ever set in BRANCH.
  assign pcen       = pcwrite | (branch & (is_bne ? ~zero : zero));
  assign alucontrol = ALUCTRL_W'(alu3);

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset, reset2;
  logic [5:0] op, funct;
  logic       zero, memready;

  logic       memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen, sig, illegal;
  logic [2:0] alucontrol;

  logic       memreq2, iord2, memwrite2, irwrite2, regdst2, memtoreg2, regwrite2, alusrca2;
  logic [1:0] alusrcb2, pcsrc2;
  logic       pcen2, sig2, illegal2;
  logic [2:0] alucontrol2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .memreq(memreq), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .pcen(pcen), .sig(sig), .alucontrol(alucontrol), .illegal(illegal)
  );

  mc_controller #(.HAS_LOGIC_IMM(1'b0)) dut_nl (
    .clk(clk), .reset(reset2), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .memreq(memreq2), .iord(iord2), .memwrite(memwrite2), .irwrite(irwrite2),
    .regdst(regdst2), .memtoreg(memtoreg2), .regwrite(regwrite2), .alusrca(alusrca2),
    .alusrcb(alusrcb2), .pcsrc(pcsrc2), .pcen(pcen2), .sig(sig2),
    .alucontrol(alucontrol2), .illegal(illegal2)
  );

  // Packed view of all outputs, MSB first in port order.
  logic [17:0] got, got2;
  assign got  = {memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, pcen, sig, alucontrol, illegal};
  assign got2 = {memreq2, iord2, memwrite2, irwrite2, regdst2, memtoreg2, regwrite2,
                 alusrca2, alusrcb2, pcsrc2, pcen2, sig2, alucontrol2, illegal2};

  function automatic logic [17:0] ov(bit a_mreq, bit a_iord, bit a_mw, bit a_irw, bit a_rd,
                                     bit a_mtr, bit a_rw, bit a_asa, logic [1:0] a_asb,
                                     logic [1:0] a_pcs, bit a_pcen, bit a_sig,
                                     logic [2:0] a_alu, bit a_ill);
    return {a_mreq, a_iord, a_mw, a_irw, a_rd, a_mtr, a_rw, a_asa, a_asb, a_pcs, a_pcen,
            a_sig, a_alu, a_ill};
  endfunction

  localparam logic [17:0] V_F1   = ov(1,0,0,1,0,0,0,0,2'b01,2'b00,1,1,3'b010,0);
  localparam logic [17:0] V_F0   = ov(1,0,0,0,0,0,0,0,2'b01,2'b00,0,1,3'b010,0);
  localparam logic [17:0] V_DEC  = ov(0,0,0,0,0,0,0,0,2'b11,2'b00,0,1,3'b010,0);
  localparam logic [17:0] V_DECI = ov(0,0,0,0,0,0,0,0,2'b11,2'b00,0,1,3'b010,1);
  localparam logic [17:0] V_MADR = ov(0,0,0,0,0,0,0,1,2'b10,2'b00,0,1,3'b010,0);
  localparam logic [17:0] V_MRD  = ov(1,1,0,0,0,0,0,0,2'b00,2'b00,0,1,3'b000,0);
  localparam logic [17:0] V_MWB  = ov(0,0,0,0,0,1,1,0,2'b00,2'b00,0,1,3'b000,0);
  localparam logic [17:0] V_MWR  = ov(1,1,1,0,0,0,0,0,2'b00,2'b00,0,1,3'b000,0);
  localparam logic [17:0] V_BR1  = ov(0,0,0,0,0,0,0,1,2'b00,2'b01,1,1,3'b110,0);
  localparam logic [17:0] V_BR0  = ov(0,0,0,0,0,0,0,1,2'b00,2'b01,0,1,3'b110,0);
  localparam logic [17:0] V_ORI  = ov(0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,3'b001,0);
  localparam logic [17:0] V_IWB  = ov(0,0,0,0,0,0,1,0,2'b00,2'b00,0,1,3'b000,0);
  localparam logic [17:0] V_SLT  = ov(0,0,0,0,0,0,0,1,2'b00,2'b00,0,1,3'b111,0);
  localparam logic [17:0] V_AWB  = ov(0,0,0,0,1,0,1,0,2'b00,2'b00,0,1,3'b000,0);
  localparam logic [17:0] V_JMP  = ov(0,0,0,0,0,0,0,0,2'b00,2'b10,1,1,3'b000,0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch with memready=1 and land in DECODE, checking both cycles.
  task automatic fetch_decode(input string tag, input logic [5:0] opc);
    op = opc;
    memready = 1'b1;
    #1 check({tag, "_fetch"}, got, V_F1);
    tick();
    check({tag, "_decode"}, got, V_DEC);
    tick();
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b0;
    op = 6'b000000; funct = 6'b100000; zero = 1'b0; memready = 1'b1;
    #2 reset = 1'b0;
    #1 check("reset_fetch", got, V_F0);
    tick();
    check("reset_hold", got, V_F0);
    reset = 1'b1;

    // lw: 5 cycles
    fetch_decode("lw", 6'b100011);
    check("lw_memadr", got, V_MADR);
    tick();
    check("lw_memrd", got, V_MRD);
    tick();
    check("lw_memwb", got, V_MWB);
    tick();

    // sw with one FETCH wait and three MEMWR waits
    memready = 1'b0;
    #1 check("sw_fetch_wait", got, V_F0);
    tick();
    fetch_decode("sw", 6'b101011);
    check("sw_memadr", got, V_MADR);
    tick();
    memready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("sw_memwr_wait%0d", i), got, V_MWR);
      tick();
    end
    memready = 1'b1;
    #1 check("sw_memwr_done", got, V_MWR);
    tick();

    // beq taken, beq not taken, bne taken, bne not taken
    fetch_decode("beq1", 6'b000100);
    zero = 1'b1;
    #1 check("beq_z1", got, V_BR1);
    zero = 1'b0;
    #1 check("beq_z0_same_cycle", got, V_BR0);
    tick();
    fetch_decode("beq0", 6'b000100);
    check("beq_z0", got, V_BR0);
    tick();
    fetch_decode("bne0", 6'b000101);
    check("bne_z0", got, V_BR1);
    zero = 1'b1;
    #1 check("bne_z1", got, V_BR0);
    zero = 1'b0;
    tick();

    // ori on both instances; the no-logic-imm one flags it illegal
    reset2 = 1'b1;
    op = 6'b001101;
    #1 check("ori_nl_fetch", got2, V_F1);
    fetch_decode("ori", 6'b001101);
    check("ori_immex", got, V_ORI);
    check("ori_nl_fetch_after_illegal", got2, V_F1);
    tick();
    check("ori_immwb", got, V_IWB);
    tick();
    reset2 = 1'b0;

    // Catch the illegal pulse on dut_nl in its DECODE cycle
    reset2 = 1'b1;
    op = 6'b001101;
    memready = 1'b1;
    tick();
    check("ori_nl_decode_illegal", got2, V_DECI);
    check("dut_decode_ori_legal", got, V_DEC);
    tick();
    check("ori_nl_back_fetch", got2, V_F1);
    check("dut_immex", got, V_ORI);
    reset2 = 1'b0;
    tick();
    check("dut_immwb2", got, V_IWB);
    tick();

    // R-type slt, then an undefined funct
    funct = 6'b101010;
    fetch_decode("slt", 6'b000000);
    check("slt_execute", got, V_SLT);
    tick();
    check("slt_aluwb", got, V_AWB);
    tick();
    funct = 6'b000111;
    fetch_decode("badfn", 6'b000000);
    check("badfn_illegal", illegal, 1);
    check("badfn_regwrite", regwrite, 0);
    check("badfn_pcen", pcen, 0);
    tick();
    check("badfn_back_fetch", got, V_F1);

    // j
    fetch_decode("j", 6'b000010);
    check("j_jump", got, V_JMP);
    tick();

    // reset during a MEMRD wait
    fetch_decode("lw2", 6'b100011);
    tick();
    memready = 1'b0;
    #1 check("lw2_memrd_wait", got, V_MRD);
    memready = 1'b1;
    reset = 1'b0;
    #1 check("reset_mid_memrd", got, V_F0);
    tick();
    check("reset_mid_hold", got, V_F0);
    reset = 1'b1;
    fetch_decode("after_reset", 6'b000010);
    check("after_reset_jump", got, V_JMP);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
